regfile_wb_arbiter: RTL and testbench

- Owns the single write port (write enable, write address, write data) of the 32x32 integer register file.
- After reset, sequences a full clear of all registers to CLEAR_VAL, then arbitrates between two writers:
  - the single-cycle core writeback, which has priority;
  - a multi-cycle unit (divider/load return), using a valid/ready handshake.
- Sits between the core writeback stage, the multi-cycle unit and reg_file.

---
 rtl/regfile_wb_if.sv | 37 +++
 rtl/regfile_wb_arbiter.sv | 138 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_if.sv
// Bundle of the register-file write-port arbiter signals.
//
// Handshake (multi-cycle unit -> arbiter): a result transfers on the posedge
// where mc_valid=1 and mc_ready=1. The producer must hold mc_rd/mc_wd stable
// while mc_valid=1 and the result is not yet accepted. mc_ready never depends
// on mc_valid (it may depend combinationally on core_we/core_rd).
//
// master: core writeback stage + multi-cycle unit + register file side.
// slave : the arbiter itself.
interface regfile_wb_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          core_we;
    logic [AW-1:0] core_rd;
    logic [DW-1:0] core_wd;
    logic          mc_valid;
    logic [AW-1:0] mc_rd;
    logic [DW-1:0] mc_wd;
    logic          mc_ready;
    logic          rf_we;
    logic [AW-1:0] rf_a3;
    logic [DW-1:0] rf_wd;
    logic          init_busy;
    logic          stall_core;
    logic          state_run;   // debug view of the FSM: 0=CLEAR, 1=RUN

    modport master (
        output core_we, core_rd, core_wd, mc_valid, mc_rd, mc_wd,
        input  mc_ready, rf_we, rf_a3, rf_wd, init_busy, stall_core, state_run
    );

    modport slave (
        input  core_we, core_rd, core_wd, mc_valid, mc_rd, mc_wd,
        output mc_ready, rf_we, rf_a3, rf_wd, init_busy, stall_core, state_run
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Write-port owner for the integer register file.
// After reset it clears every register to CLEAR_VAL, one per cycle, then
// arbitrates the single write port between the core writeback (priority) and
// a multi-cycle unit using a valid/ready handshake.
// Optional starvation guard: define REGWB_STARVE_GUARD_EN. When enabled, an
// mc result waiting STARVE_LIMIT cycles earns one cycle of mc priority, during
// which stall_core tells the core to replay its write.
module regfile_wb_arbiter #(
    parameter int              NREG         = 32,
    parameter int              AW           = 5,
    parameter int              DW           = 32,
    parameter logic [DW-1:0]   CLEAR_VAL    = '0,
    parameter int              STARVE_LIMIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    regfile_wb_if.slave bus
);
    typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_e;

    localparam logic [AW:0] CLR_LAST = (AW+1)'(NREG - 1);

    if (STARVE_LIMIT < 1) begin : g_bad_limit
        $error("STARVE_LIMIT must be at least 1");
    end

    state_e        state_q, state_d;
    logic [AW:0]   clr_idx_q, clr_idx_d;
    logic          core_req;
    logic          mc_pri;
    logic          mc_ready_c;
    logic          rf_we_c;
    logic [AW-1:0] rf_a3_c;
    logic [DW-1:0] rf_wd_c;
    logic          init_busy_c;

`ifdef REGWB_STARVE_GUARD_EN
    localparam int            CW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          stall_q, stall_d;

    assign mc_pri = stall_q;
`else
    assign mc_pri = 1'b0;
`endif

    assign core_req = bus.core_we && (bus.core_rd != '0);

    // Next-state and write-port mux: clear sequence, then core-first arbitration.
    always_comb begin
        state_d     = state_q;
        clr_idx_d   = clr_idx_q;
        rf_we_c     = 1'b0;
        rf_a3_c     = '0;
        rf_wd_c     = '0;
        mc_ready_c  = 1'b0;
        init_busy_c = 1'b0;
        if (rst) begin
            state_d     = CLEAR;
            clr_idx_d   = '0;
            init_busy_c = 1'b1;
        end else if (state_q == CLEAR) begin
            rf_we_c     = 1'b1;
            rf_a3_c     = clr_idx_q[AW-1:0];
            rf_wd_c     = CLEAR_VAL;
            init_busy_c = 1'b1;
            clr_idx_d   = clr_idx_q + 1'b1;
            if (clr_idx_q == CLR_LAST) begin
                state_d = RUN;
            end
        end else begin
            // mc is offered the port whenever the core does not claim it
            // (x0 writes from the core are not a claim).
            mc_ready_c = mc_pri || !core_req;
            if (!mc_ready_c) begin
                rf_we_c = 1'b1;
                rf_a3_c = bus.core_rd;
                rf_wd_c = bus.core_wd;
            end else if (bus.mc_valid && (bus.mc_rd != '0)) begin
                rf_we_c = 1'b1;
                rf_a3_c = bus.mc_rd;
                rf_wd_c = bus.mc_wd;
            end
        end
    end

    // FSM and clear-index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

`ifdef REGWB_STARVE_GUARD_EN
    // Count cycles an mc result is refused; at the limit grant mc one cycle.
    always_comb begin
        wait_cnt_d = '0;
        stall_d    = 1'b0;
        if (!rst && state_q == RUN) begin
            if (bus.mc_valid && !mc_ready_c) begin
                wait_cnt_d = wait_cnt_q + CW'(1);
            end
            if (wait_cnt_d == LIMIT) begin
                stall_d    = 1'b1;
                wait_cnt_d = '0;
            end
        end
    end

    // Starvation counter and registered stall flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= '0;
            stall_q    <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            stall_q    <= stall_d;
        end
    end

    assign bus.stall_core = stall_q && !rst;
`else
    assign bus.stall_core = 1'b0;
`endif

    assign bus.mc_ready  = mc_ready_c;
    assign bus.rf_we     = rf_we_c;
    assign bus.rf_a3     = rf_a3_c;
    assign bus.rf_wd     = rf_wd_c;
    assign bus.init_busy = init_busy_c;
    assign bus.state_run = (state_q == RUN);
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus random
// RUN traffic, checked against a cycle-level reference model and a reference
// copy of the register file contents.
module tb_regfile_wb_arbiter;
    localparam int NREG  = 32;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int LIMIT = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_wb_if #(.AW(AW), .DW(DW)) bus ();

    regfile_wb_arbiter #(
        .NREG(NREG), .AW(AW), .DW(DW), .CLEAR_VAL('0), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // ---------------- scoreboard state ----------------
    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: registers cleared since reset (NREG => running).
    int clr_cnt = 0;
    int starve  = 0;
    bit stall_exp = 1'b0;
    logic [DW-1:0] ref_rf [NREG];
    logic [DW-1:0] dut_rf [NREG];
    logic [DW-1:0] exp_q [$];   // data of accepted mc results, in order

    // Persistent mc-side stimulus (held until accepted).
    bit            mv  = 1'b0;
    logic [AW-1:0] mrd = '0;
    logic [DW-1:0] mwd = '0;
    bit            last_acc = 1'b0;

    // Last observed outputs.
    logic          o_we, o_ready, o_busy, o_stall;
    logic [AW-1:0] o_a3;
    logic [DW-1:0] o_wd;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] rand_rd();
        logic [AW-1:0] r;
        r = ($urandom_range(0, 5) == 0) ? '0 : AW'($urandom_range(1, NREG - 1));
        return r;
    endfunction

    // ---------------- driver + model, one clock per call ----------------
    task automatic step(input bit r, input bit cwe, input logic [AW-1:0] crd,
                        input logic [DW-1:0] cwd);
        bit            e_we, e_ready, e_busy, e_stall, core_ok;
        logic [AW-1:0] e_a3;
        logic [DW-1:0] e_wd;
        rst          = r;
        bus.core_we  = cwe;
        bus.core_rd  = crd;
        bus.core_wd  = cwd;
        bus.mc_valid = mv;
        bus.mc_rd    = mrd;
        bus.mc_wd    = mwd;
        @(negedge clk);
        o_we = bus.rf_we; o_a3 = bus.rf_a3; o_wd = bus.rf_wd;
        o_ready = bus.mc_ready; o_busy = bus.init_busy; o_stall = bus.stall_core;

        // Expected outputs from the behavioural rules.
        e_we = 0; e_a3 = '0; e_wd = '0; e_ready = 0; e_busy = 0; e_stall = 0;
        if (r) begin
            e_busy = 1;
        end else if (clr_cnt < NREG) begin
            e_we = 1; e_a3 = AW'(clr_cnt); e_wd = '0; e_busy = 1;
        end else begin
            e_stall = stall_exp;
            core_ok = cwe && (crd != 0) && !stall_exp;
            e_ready = !core_ok;
            if (core_ok) begin
                e_we = 1; e_a3 = crd; e_wd = cwd;
            end else if (mv && mrd != 0) begin
                e_we = 1; e_a3 = mrd; e_wd = mwd;
            end
        end
        check("rf_we", DW'(o_we), DW'(e_we));
        check("rf_a3", DW'(o_a3), DW'(e_a3));
        check("rf_wd", o_wd, e_wd);
        check("mc_ready", DW'(o_ready), DW'(e_ready));
        check("init_busy", DW'(o_busy), DW'(e_busy));
        check("stall_core", DW'(o_stall), DW'(e_stall));

        if (e_we) ref_rf[e_a3] = e_wd;
        if (o_we === 1'b1) dut_rf[o_a3] = o_wd;
        last_acc = mv && e_ready;
        if (last_acc) exp_q.push_back(mwd);
        if (o_ready === 1'b1 && mv) begin
            if (exp_q.size() == 0) begin
                check("mc_accept_unexpected", DW'(1), DW'(0));
            end else begin
                check("mc_accept_data", mwd, exp_q.pop_front());
            end
        end

        @(posedge clk);
        if (r) begin
            clr_cnt = 0; starve = 0; stall_exp = 0;
        end else if (clr_cnt < NREG) begin
            clr_cnt++;
        end else begin
`ifdef REGWB_STARVE_GUARD_EN
            if (mv && !e_ready) starve++; else starve = 0;
            stall_exp = (starve == LIMIT);
            if (stall_exp) starve = 0;
`endif
        end
        #1;
    endtask

    // New mc transaction only once the previous one was accepted or none pending.
    task automatic next_mc();
        if (!mv || last_acc) begin
            mv  = ($urandom_range(0, 2) != 0);
            mrd = rand_rd();
            mwd = $urandom;
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        for (int i = 0; i < NREG; i++) begin
            ref_rf[i] = 32'hdead_0000 | DW'(i);
            dut_rf[i] = 32'hdead_0000 | DW'(i);
        end
        rst = 1'b1;
        bus.core_we = 0; bus.core_rd = '0; bus.core_wd = '0;
        bus.mc_valid = 0; bus.mc_rd = '0; bus.mc_wd = '0;
        #1;

        // Reset with traffic present.
        mv = 1; mrd = 5'd3; mwd = 32'h1234;
        step(1, 1, 5'd7, 32'h77);
        step(1, 1, 5'd7, 32'h77);

        // Full clear; core and mc requests must be ignored.
        for (int i = 0; i < NREG; i++) begin
            step(0, 1'($urandom_range(0, 1)), rand_rd(), $urandom);
            check("clear_addr", DW'(o_a3), DW'(i));
            check("clear_ready", DW'(o_ready), DW'(0));
        end

        // Core wins over mc, then mc goes through.
        mv = 1; mrd = 5'd9; mwd = 32'h99;
        step(0, 1, 5'd5, 32'h25);
        check("dir_busy_low", DW'(o_busy), DW'(0));
        check("dir_core_a3", DW'(o_a3), DW'(5));
        check("dir_core_wd", o_wd, 32'h25);
        check("dir_core_ready", DW'(o_ready), DW'(0));
        step(0, 0, 5'd5, 32'h25);
        check("dir_mc_a3", DW'(o_a3), DW'(9));
        check("dir_mc_ready", DW'(o_ready), DW'(1));

        // Core write to x0 is not a claim: mc granted.
        mv = 1; mrd = 5'd12; mwd = 32'h30;
        step(0, 1, 5'd0, 32'h55);
        check("dir_x0_we", DW'(o_we), DW'(1));
        check("dir_x0_a3", DW'(o_a3), DW'(12));

        // mc result for x0 is consumed without a write.
        mv = 1; mrd = 5'd0; mwd = 32'h66;
        step(0, 0, 5'd0, 32'h0);
        check("dir_mcx0_ready", DW'(o_ready), DW'(1));
        check("dir_mcx0_we", DW'(o_we), DW'(0));
        mv = 0;
        step(0, 0, 5'd0, 32'h0);

        // Random RUN traffic obeying the hold-until-accepted rule.
        for (int i = 0; i < 200; i++) begin
            next_mc();
            step(0, ($urandom_range(0, 3) != 0), rand_rd(), $urandom);
        end

        // Reset at clear index 10 restarts the clear from 0.
        mv = 1; mrd = 5'd4; mwd = 32'h44;
        step(1, 0, 5'd0, 32'h0);
        for (int i = 0; i < 10; i++) step(0, 1, 5'd8, 32'h88);
        step(1, 1, 5'd8, 32'h88);
        for (int i = 0; i < NREG; i++) begin
            step(0, 1, 5'd8, 32'h88);
            check("reclear_addr", DW'(o_a3), DW'(i));
        end
        step(0, 0, 5'd0, 32'h0);   // pending mc result drains
        check("reclear_mc_a3", DW'(o_a3), DW'(4));

        // Starvation: core writes x6 every cycle, mc keeps x11 pending.
        mv = 0;
        step(0, 0, 5'd0, 32'h0);
        mv = 1; mrd = 5'd11; mwd = 32'hbb;
        for (int i = 0; i < 12; i++) begin
            step(0, 1, 5'd6, 32'h6 + DW'(i));
`ifdef REGWB_STARVE_GUARD_EN
            check("starve_stall", DW'(o_stall), DW'(i == LIMIT));
            check("starve_a3", DW'(o_a3), (i == LIMIT) ? DW'(11) : DW'(6));
`else
            check("starve_stall", DW'(o_stall), DW'(0));
            check("starve_ready", DW'(o_ready), DW'(0));
`endif
        end
        mv = 0;
        step(0, 0, 5'd0, 32'h0);

        // Final register contents against the reference copy.
        for (int i = 0; i < NREG; i++) begin
            check($sformatf("rf_content_x%0d", i), dut_rf[i], ref_rf[i]);
        end
        check("rf_x0_zero", dut_rf[0], '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
